axi4_burst_led_slave: RTL and testbench



---
 rtl/axi4_burst_led_slave.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi4_burst_led_slave.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_led_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_led_slave
// Description : AXI4 burst slave that holds a small 32-bit register file.
//               Word 0 bits [LED_WIDTH-1:0] drive the board LEDs through one
//               register stage. The write and read channels are independent
//               state machines, each with one outstanding transaction.
//               Optional feature macro: AXI4_SLAVE_WSTRB_EN. When it is
//               defined, WSTRB gates individual byte lanes. When it is
//               undefined, all four bytes are always written.
// Ports       : ACLK, ARESET (sync, active-high)
//               S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address/data/response
//               S_AXI_AR* / S_AXI_R*             read address/data
//               LED                              registered word0[LED_WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_led_slave #(
    parameter int REG_DEPTH_LOG2     = 4,
    parameter int LED_WIDTH          = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    // write address
    input  logic                          S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    // write data
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    // write response
    output logic                          S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // read address
    input  logic                          S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    // read data
    output logic                          S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // board LEDs
    output logic [LED_WIDTH-1:0]          LED
);

    localparam int          IW          = REG_DEPTH_LOG2;
    localparam int          DEPTH       = 1 << REG_DEPTH_LOG2;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [1:0]  W_IDLE = 2'd0;
    localparam logic [1:0]  W_DATA = 2'd1;
    localparam logic [1:0]  W_RESP = 2'd2;

    localparam logic        R_IDLE = 1'b0;
    localparam logic        R_DATA = 1'b1;

    // Address bits above the word index are ignored, so the register file aliases.
    logic unused_addr_bits;
`ifdef AXI4_SLAVE_WSTRB_EN
    assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_ARADDR[1:0]};
`else
    assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IW+2], S_AXI_ARADDR[1:0],
                                S_AXI_WSTRB};
`endif

    // Low for the first cycle after reset so both READY outputs stay 0 during reset.
    logic active_q;

    logic [31:0]          mem_q [DEPTH];
    logic [LED_WIDTH-1:0] led_q;

    // ---------------- write channel state ----------------
    logic [1:0]    w_state_q, w_state_d;
    logic          w_id_q,    w_id_d;
    logic [IW-1:0] w_idx_q,   w_idx_d;
    logic [7:0]    w_len_q,   w_len_d;
    logic [1:0]    w_burst_q, w_burst_d;
    logic [8:0]    w_cnt_q,   w_cnt_d;
    logic          w_err_q,   w_err_d;
    logic          w_we;
    logic          w_aw_hs;

    // ---------------- read channel state ----------------
    logic          r_state_q, r_state_d;
    logic          r_id_q,    r_id_d;
    logic [IW-1:0] r_idx_q,   r_idx_d;
    logic [7:0]    r_len_q,   r_len_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic [8:0]    r_cnt_q,   r_cnt_d;
    logic          r_err_q,   r_err_d;
    logic [31:0]   r_data_q,  r_data_d;
    logic          r_last_q,  r_last_d;
    logic [IW-1:0] r_nidx;
    logic [IW-1:0] r_ar_idx;
    logic          r_ar_err;
    logic          r_ar_hs;

    assign S_AXI_AWREADY = active_q && (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BID     = w_id_q;
    assign S_AXI_BRESP   = (S_AXI_BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign S_AXI_ARREADY = active_q && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RID     = r_id_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RLAST   = r_last_q;
    assign S_AXI_RRESP   = (S_AXI_RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign LED = led_q;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign r_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // ---------------- write FSM ----------------
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_id_d    = S_AXI_AWID;
                    w_idx_d   = S_AXI_AWADDR[IW+1:2];
                    w_len_d   = S_AXI_AWLEN;
                    w_burst_d = S_AXI_AWBURST;
                    w_cnt_d   = 9'd0;
                    w_err_d   = (S_AXI_AWSIZE != SIZE_WORD) || (S_AXI_AWBURST == BURST_WRAP);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    // The flag in effect at this beat decides the write; a
                    // WLAST error raised here only affects later beats.
                    w_we    = !w_err_q;
                    w_cnt_d = w_cnt_q + 9'd1;
                    if (w_burst_q == BURST_INCR) begin
                        w_idx_d = w_idx_q + 1'b1;
                    end
                    if (w_cnt_q == {1'b0, w_len_q}) begin
                        w_state_d = W_RESP;
                        if (!S_AXI_WLAST) begin
                            w_err_d = 1'b1;
                        end
                    end else if (S_AXI_WLAST) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    assign r_nidx   = (r_burst_q == BURST_INCR) ? (r_idx_q + 1'b1) : r_idx_q;
    assign r_ar_idx = S_AXI_ARADDR[IW+1:2];
    assign r_ar_err = (S_AXI_ARSIZE != SIZE_WORD) || (S_AXI_ARBURST == BURST_WRAP);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        r_data_d  = r_data_q;
        r_last_d  = r_last_q;
        case (r_state_q)
            R_IDLE: begin
                if (r_ar_hs) begin
                    r_id_d    = S_AXI_ARID;
                    r_idx_d   = r_ar_idx;
                    r_len_d   = S_AXI_ARLEN;
                    r_burst_d = S_AXI_ARBURST;
                    r_cnt_d   = 9'd0;
                    r_err_d   = r_ar_err;
                    // Loaded from the registered array, so a write landing on
                    // the same edge is not yet visible here.
                    r_data_d  = r_ar_err ? 32'd0 : mem_q[r_ar_idx];
                    r_last_d  = (S_AXI_ARLEN == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (r_cnt_q == {1'b0, r_len_q}) begin
                        r_last_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d  = r_nidx;
                        r_cnt_d  = r_cnt_q + 9'd1;
                        r_data_d = r_err_q ? 32'd0 : mem_q[r_nidx];
                        r_last_d = ((r_cnt_q + 9'd1) == {1'b0, r_len_q});
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            active_q  <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= 1'b0;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_cnt_q   <= 9'd0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= 1'b0;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_cnt_q   <= 9'd0;
            r_err_q   <= 1'b0;
            r_data_q  <= 32'd0;
            r_last_q  <= 1'b0;
            led_q     <= '0;
        end else begin
            active_q  <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            r_data_q  <= r_data_d;
            r_last_q  <= r_last_d;
            // LED follows word 0 one cycle after the word itself changes.
            led_q     <= mem_q[0][LED_WIDTH-1:0];
        end
    end

    // ---------------- register file ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (w_we) begin
`ifdef AXI4_SLAVE_WSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
`else
            mem_q[w_idx_q] <= S_AXI_WDATA;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_led_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_led_slave
// Description : Directed self-checking bench for axi4_burst_led_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_led_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic        ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic        RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [3:0]  LED;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic        rd_id   [16];

    logic [1:0]  bresp_s;
    logic        bid_s;

    always #5 ACLK = ~ACLK;

    axi4_burst_led_slave #(
        .REG_DEPTH_LOG2    (4),
        .LED_WIDTH         (4),
        .C_S_AXI_ADDR_WIDTH(32)
    ) u_dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWID    (AWID),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWLEN   (AWLEN),
        .S_AXI_AWSIZE  (AWSIZE),
        .S_AXI_AWBURST (AWBURST),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WLAST   (WLAST),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BID     (BID),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARID    (ARID),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARLEN   (ARLEN),
        .S_AXI_ARSIZE  (ARSIZE),
        .S_AXI_ARBURST (ARBURST),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RID     (RID),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RLAST   (RLAST),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .LED           (LED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) chk("aw_timeout", 32'd1, 32'd0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) chk("ar_timeout", 32'd1, 32'd0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    // Beat i carries base+i; badlast drops WLAST on the final beat.
    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] base, input int gapmax, input int bdelay,
                             input bit badlast, output logic [1:0] bresp, output logic bid);
        int t;
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(0, gapmax)) begin @(posedge ACLK); #1; end
            WDATA  = base + i;
            WSTRB  = 4'hF;
            WLAST  = (i == int'(len)) && !badlast;
            WVALID = 1'b1;
            t = 0;
            @(negedge ACLK);
            while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
            if (t >= 50) chk("w_timeout", 32'd1, 32'd0);
            @(posedge ACLK); #1;
            WVALID = 1'b0;
            WLAST  = 1'b0;
        end
        t = 0;
        @(negedge ACLK);
        while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) chk("b_timeout", 32'd1, 32'd0);
        bresp = BRESP;
        bid   = BID;
        for (int d = 0; d < bdelay; d++) begin
            chk("bvalid_held", {31'd0, BVALID}, 32'd1);
            chk("awready_low_in_resp", {31'd0, AWREADY}, 32'd0);
            @(posedge ACLK); @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    // Captures every beat into rd_*; checks RDATA/RLAST/RRESP stay put while stalled.
    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stallmax);
        int t;
        logic [31:0] held;
        logic        held_last;
        ar_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            @(negedge ACLK);
            while (!RVALID && t < 50) begin @(negedge ACLK); t++; end
            if (t >= 50) chk("r_timeout", 32'd1, 32'd0);
            held      = RDATA;
            held_last = RLAST;
            repeat ($urandom_range(0, stallmax)) begin
                @(posedge ACLK); @(negedge ACLK);
                chk("rvalid_stall", {31'd0, RVALID}, 32'd1);
                chk("rdata_stable", RDATA, held);
                chk("rlast_stable", {31'd0, RLAST}, {31'd0, held_last});
            end
            RREADY = 1'b1;
            if (i < 16) begin
                rd_data[i] = RDATA; rd_last[i] = RLAST; rd_resp[i] = RRESP; rd_id[i] = RID;
            end
            @(posedge ACLK); #1;
            RREADY = 1'b0;
        end
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;

        // ---- reset state ----
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", {31'd0, AWREADY}, 32'd0);
        chk("rst_arready", {31'd0, ARREADY}, 32'd0);
        chk("rst_wready",  {31'd0, WREADY},  32'd0);
        chk("rst_bvalid",  {31'd0, BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, RVALID},  32'd0);
        chk("rst_rdata",   RDATA,            32'd0);
        chk("rst_led",     {28'd0, LED},     32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_before_first_clk", {31'd0, AWREADY}, 32'd0);
        @(posedge ACLK); #1;
        chk("awready_after_release", {31'd0, AWREADY}, 32'd1);
        chk("arready_after_release", {31'd0, ARREADY}, 32'd1);

        // ---- single write to word 0, WVALID early is not accepted ----
        WVALID = 1'b1; WDATA = 32'hFFFF_FFFF;
        @(negedge ACLK);
        chk("wready_before_aw", {31'd0, WREADY}, 32'd0);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        axi_write(1'b1, 32'h0, 8'd0, 3'b010, 2'b01, 32'h0000_000A, 0, 0, 1'b0, bresp_s, bid_s);
        chk("single_bresp", {30'd0, bresp_s}, 32'd0);
        chk("single_bid",   {31'd0, bid_s},   32'd1);
        chk("single_led",   {28'd0, LED},     32'hA);

        // ---- INCR burst wrapping past word 15 ----
        axi_write(1'b0, 32'h38, 8'd3, 3'b010, 2'b01, 32'h100, 3, 0, 1'b0, bresp_s, bid_s);
        chk("incr_bresp", {30'd0, bresp_s}, 32'd0);
        chk("incr_bid",   {31'd0, bid_s},   32'd0);
        @(posedge ACLK); #1;
        chk("incr_led_word0", {28'd0, LED}, 32'h2);
        axi_read(1'b1, 32'h38, 8'd3, 3'b010, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_data[i], 32'h100 + i);
            chk("incr_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
            chk("incr_rresp", {30'd0, rd_resp[i]}, 32'd0);
            chk("incr_rid",   {31'd0, rd_id[i]},   32'd1);
        end

        // ---- FIXED burst: last beat wins; stalled read ----
        axi_write(1'b0, 32'h8, 8'd2, 3'b010, 2'b00, 32'd1, 1, 0, 1'b0, bresp_s, bid_s);
        chk("fixed_bresp", {30'd0, bresp_s}, 32'd0);
        axi_read(1'b0, 32'h8, 8'd2, 3'b010, 2'b00, 3);
        for (int i = 0; i < 3; i++) begin
            chk("fixed_rdata", rd_data[i], 32'd3);
            chk("fixed_rlast", {31'd0, rd_last[i]}, (i == 2) ? 32'd1 : 32'd0);
        end

        // ---- WRAP write rejected, register untouched ----
        axi_write(1'b1, 32'h8, 8'd0, 3'b010, 2'b10, 32'hDEAD_BEEF, 0, 0, 1'b0, bresp_s, bid_s);
        chk("wrap_bresp", {30'd0, bresp_s}, 32'd2);
        axi_read(1'b0, 32'h8, 8'd0, 3'b010, 2'b01, 0);
        chk("wrap_unchanged", rd_data[0], 32'd3);

        // ---- bad ARSIZE read ----
        axi_read(1'b0, 32'h38, 8'd1, 3'b001, 2'b01, 0);
        for (int i = 0; i < 2; i++) begin
            chk("badsize_rresp", {30'd0, rd_resp[i]}, 32'd2);
            chk("badsize_rdata", rd_data[i], 32'd0);
        end

        // ---- missing WLAST on final beat ----
        axi_write(1'b0, 32'h20, 8'd1, 3'b010, 2'b01, 32'h77, 0, 0, 1'b1, bresp_s, bid_s);
        chk("nolast_bresp", {30'd0, bresp_s}, 32'd2);

        // ---- delayed BREADY with a concurrent read ----
        fork
            axi_write(1'b1, 32'h10, 8'd0, 3'b010, 2'b01, 32'h55, 0, 5, 1'b0, bresp_s, bid_s);
            axi_read(1'b1, 32'h38, 8'd3, 3'b010, 2'b01, 1);
        join
        chk("bdelay_bresp", {30'd0, bresp_s}, 32'd0);
        chk("bdelay_bid",   {31'd0, bid_s},   32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("concurrent_rdata", rd_data[i], 32'h100 + i);
        end
        axi_read(1'b0, 32'h10, 8'd0, 3'b010, 2'b01, 0);
        chk("bdelay_word4", rd_data[0], 32'h55);

        // ---- reset in the middle of a read ----
        ar_send(1'b0, 32'h0, 8'd7, 3'b010, 2'b01);
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("midrst_beat1_valid", {31'd0, RVALID}, 32'd1);
        chk("midrst_beat1_data",  RDATA, 32'h102);
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("midrst_beat2_data", RDATA, 32'h103);
        chk("midrst_led_before", {28'd0, LED}, 32'h2);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        chk("midrst_rvalid", {31'd0, RVALID},  32'd0);
        chk("midrst_rdata",  RDATA,            32'd0);
        chk("midrst_led",    {28'd0, LED},     32'd0);
        chk("midrst_arready",{31'd0, ARREADY}, 32'd0);
        chk("midrst_awready",{31'd0, AWREADY}, 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("midrst_ready_low_pre", {31'd0, ARREADY}, 32'd0);
        @(posedge ACLK); #1;
        chk("midrst_awready_up", {31'd0, AWREADY}, 32'd1);
        chk("midrst_arready_up", {31'd0, ARREADY}, 32'd1);
        chk("midrst_no_bvalid",  {31'd0, BVALID},  32'd0);
        axi_read(1'b0, 32'h0, 8'd15, 3'b010, 2'b01, 0);
        for (int i = 0; i < 16; i++) begin
            chk("midrst_word_cleared", rd_data[i], 32'd0);
        end
        chk("midrst_last_rlast", {31'd0, rd_last[15]}, 32'd1);

        repeat (2) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
